// File: rtl/result_writer.sv
// result_writer
//   Takes a raster-ordered (column fastest, then row) stream of result words
//   and writes each one to its row-major output-buffer address.
//   A 2-entry buffer sits between the accept side and the memory port so that
//   memory stalls are absorbed without dropping words. The block pulses done
//   once a full WIDTH x HEIGHT frame has been committed to memory.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             arms one frame (honoured only in IDLE)
//   in_valid/in_data  upstream result word; in_ready is the accept handshake
//   mem_we/mem_addr/mem_wdata/mem_ack
//                     write port; a request holds until mem_we && mem_ack
//   col_cntr/row_cntr position of the next word to be accepted
//   busy              frame in progress (state != IDLE)
//   done              one-cycle pulse at frame completion
//   overrun_err       sticky: word offered while not accepting
module result_writer #(
    parameter int WIDTH     = 32,
    parameter int HEIGHT    = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic [CW-1:0]     col_cntr,
    output logic [RW-1:0]     row_cntr,
    output logic              busy,
    output logic              done,
    output logic              overrun_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [1:0]        count;       // occupied buffer entries (0..2)
    logic [1:0]        count_next;
    logic [ADDR_W-1:0] addr1;       // second buffer slot; head lives in mem_addr/mem_wdata
    logic [DATA_W-1:0] data1;
    logic              accept;
    logic              pop;
    logic              last;
    logic              col_last;
    logic              row_last;
    logic [ADDR_W-1:0] wr_addr;

    assign in_ready = (state == S_RUN) && (count != 2'd2);
    assign mem_we   = (count != 2'd0);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && in_ready;
    assign pop      = mem_we && mem_ack;

    assign col_last = (col_cntr == CW'(WIDTH - 1));
    assign row_last = (row_cntr == RW'(HEIGHT - 1));
    assign last     = col_last && row_last;

    // Whole address expression is kept at ADDR_W so overflow wraps modulo 2^ADDR_W.
    assign wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(row_cntr) * ADDR_W'(WIDTH)
                   + ADDR_W'(col_cntr);

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Two-entry buffer. The head is the registered memory request itself, so
    // it holds stable for as long as mem_ack stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr1     <= '0;
            data1     <= '0;
        end else begin
            count <= count_next;
            case ({accept, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        mem_addr  <= wr_addr;
                        mem_wdata <= in_data;
                    end else begin
                        addr1 <= wr_addr;
                        data1 <= in_data;
                    end
                end
                2'b01: begin
                    mem_addr  <= addr1;
                    mem_wdata <= data1;
                end
                // Push and pop together only happens at count 1: new word becomes head.
                2'b11: begin
                    mem_addr  <= wr_addr;
                    mem_wdata <= in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            col_cntr    <= '0;
            row_cntr    <= '0;
            overrun_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        col_cntr    <= '0;
                        row_cntr    <= '0;
                        overrun_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col_cntr <= '0;
                            row_cntr <= row_last ? '0 : row_cntr + 1'b1;
                        end else begin
                            col_cntr <= col_cntr + 1'b1;
                        end
                        if (last) state <= S_DRAIN;
                    end
                end
                // Looking at the post-pop count lets DONE follow the final ack directly.
                S_DRAIN: if (count_next == 2'd0) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // A word offered outside RUN is dropped and flagged; this set wins
            // over the clear from a start in the same cycle.
            if (in_valid && state != S_RUN) overrun_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Testbench for result_writer: randomized valid/start/ack/reset stimulus
// checked every cycle against a frame-level model in which the k-th word of a
// frame must land at BASE + k, writes leave in FIFO order, and the buffer
// holds at most two words.
module tb_result_writer;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int BASE = 16;
    localparam int CW   = 2;
    localparam int RW   = 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          mem_ack  = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [CW-1:0] col_cntr;
    logic [RW-1:0] row_cntr;
    logic          busy;
    logic          done;
    logic          overrun_err;

    always #5 clk = ~clk;

    result_writer #(
        .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .col_cntr(col_cntr), .row_cntr(row_cntr),
        .busy(busy), .done(done), .overrun_err(overrun_err)
    );

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;

    mst_t             mst;
    int               k;          // words accepted in the current frame
    bit               movr;
    logic [AW+DW-1:0] q[$];       // pending writes {addr, data}
    int               n_chk    = 0;
    int               n_pass   = 0;
    int               dut_done = 0;
    int               mdl_done = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic mdl_reset();
        mst  = M_IDLE;
        k    = 0;
        movr = 1'b0;
        q.delete();
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model to what the coming rising edge should produce.
    task automatic cyc(input bit v, input bit s, input bit a, input bit r);
        logic [DW-1:0] d;
        logic [AW-1:0] ea;
        bit            acc;
        bit            pop;
        mst_t          prev;
        @(negedge clk);
        d        = $urandom;
        in_valid = v;
        in_data  = d;
        start    = s;
        mem_ack  = a;
        rst      = r;
        #1;
        chk("in_ready", in_ready, (mst == M_RUN) && (q.size() < 2));
        chk("mem_we",   mem_we,   q.size() != 0);
        chk("busy",     busy,     mst != M_IDLE);
        chk("done",     done,     mst == M_DONE);
        chk("col",      col_cntr, k % W);
        chk("row",      row_cntr, (k / W) % H);
        chk("overrun",  overrun_err, movr);
        if (q.size() != 0) begin
            chk("mem_addr",  mem_addr,  q[0][AW+DW-1:DW]);
            chk("mem_wdata", mem_wdata, q[0][DW-1:0]);
        end
        if (done) dut_done++;
        if (r) begin
            mdl_reset();
        end else begin
            acc  = v && (mst == M_RUN) && (q.size() < 2);
            pop  = (q.size() != 0) && a;
            prev = mst;
            if (pop) void'(q.pop_front());
            if (acc) begin
                ea = AW'(BASE + k);
                q.push_back({ea, d});
                k++;
            end
            case (mst)
                M_IDLE:  if (s) begin mst = M_RUN; k = 0; movr = 1'b0; end
                M_RUN:   if (acc && k == W * H) mst = M_DRAIN;
                M_DRAIN: if (q.size() == 0) mst = M_DONE;
                M_DONE:  begin mst = M_IDLE; mdl_done++; end
                default: mst = M_IDLE;
            endcase
            if (v && prev != M_RUN) movr = 1'b1;
        end
    endtask

    initial begin
        bit v, s, a, r;
        int ack_pct;
        mdl_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_in_ready",  in_ready,  0);

        // Word offered in IDLE: flagged, nothing written; start then clears it.
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);

        // Back-to-back frames with a free memory; start held high the whole
        // time, so it is also exercised (and ignored) during RUN/DRAIN/DONE.
        for (int i = 0; i < 64; i++) cyc(mst == M_RUN, 1, 1, 0);

        // Mid-frame reset with two writes still buffered.
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        // Fresh frame after the reset must start again at BASE.
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 20; i++) cyc(mst == M_RUN, 0, 1, 0);

        // Randomized traffic with varying memory back-pressure and rare resets.
        ack_pct = 100;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 100;
                    1:       ack_pct = 60;
                    default: ack_pct = 15;
                endcase
            end
            s = ($urandom_range(0, 5) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (mst == M_IDLE && s) v = 1'b0;
            a = ($urandom_range(0, 99) < ack_pct);
            r = ($urandom_range(0, 399) == 0);
            cyc(v, s, a, r);
        end

        chk("done_count", dut_done, mdl_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
